// File: rtl/w5500_spi_responder.sv
// W5500-style SPI slave: decodes the address/control header and turns the data
// phase into byte-wide read/write strobes on a memory port.
//
// state   | meaning
// IDLE    | deselected, waiting for a CS falling event
// ADDR_HI | shifting in address bits [15:8]
// ADDR_LO | shifting in address bits [7:0]
// CTRL    | shifting in {bsb, rwb, om}
// DATA    | data phase: write strobes or read prefetch plus MISO shifting
module w5500_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        MISO_IDLE   = 1'b0
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_spi_cs,
    input  logic        i_spi_dclk,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_spi_miso_oe,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    output logic [4:0]  o_mem_bsb,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wrdata,
    input  logic [7:0]  i_mem_rddata,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic [15:0] o_byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CTRL,
        S_DATA
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic cs_prev_q, dclk_prev_q;
    logic cs_s, dclk_s, mosi_s;
    logic cs_rise, cs_fall, dclk_rise, dclk_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic [7:0]  rd_buf_q, rd_buf_d;
    logic        rd_pend_q, rd_pend_d;
    logic [15:0] addr_q, addr_d;
    logic [4:0]  bsb_q, bsb_d;
    logic        rwb_q, rwb_d;
    logic [1:0]  om_q, om_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        err_q, err_d;
    logic        miso_q, miso_d;
    logic        wren_q, wren_d;
    logic        rden_q, rden_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  wrdata_q, wrdata_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic [15:0] byte_cnt_out_q, byte_cnt_out_d;

    logic [7:0]  rx_next;
    logic [15:0] fixed_len;
    logic        fixed_full;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign dclk_s = dclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_rise   = ~cs_prev_q & cs_s;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign dclk_rise = ~dclk_prev_q & dclk_s;
    assign dclk_fall = dclk_prev_q & ~dclk_s;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs};
        dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], i_spi_dclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
    end

    always_comb begin
        case (om_q)
            2'b01:   fixed_len = 16'd1;
            2'b10:   fixed_len = 16'd2;
            2'b11:   fixed_len = 16'd4;
            default: fixed_len = 16'd0;
        endcase
        fixed_full = (om_q != 2'b00) && (byte_cnt_q >= fixed_len);
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_sr_d        = rx_sr_q;
        tx_sr_d        = tx_sr_q;
        addr_d         = addr_q;
        bsb_d          = bsb_q;
        rwb_d          = rwb_q;
        om_d           = om_q;
        byte_cnt_d     = byte_cnt_q;
        err_d          = err_q;
        miso_d         = (state_q == S_DATA) ? miso_q : MISO_IDLE;
        wren_d         = 1'b0;
        rden_d         = 1'b0;
        mem_addr_d     = mem_addr_q;
        wrdata_d       = wrdata_q;
        done_d         = 1'b0;
        ferr_d         = 1'b0;
        byte_cnt_out_d = byte_cnt_out_q;
        rd_pend_d      = rden_q;
        rd_buf_d       = rd_pend_q ? i_mem_rddata : rd_buf_q;
        rx_next        = {rx_sr_q[6:0], mosi_s};

        if (cs_rise) begin
            // CS wins over any dclk edge in the same cycle; a partial byte is dropped
            if (state_q != S_IDLE) begin
                if (err_q || (bit_cnt_q != 3'd0) || (state_q != S_DATA) ||
                    ((om_q != 2'b00) && (byte_cnt_q < fixed_len))) begin
                    ferr_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
                byte_cnt_out_d = byte_cnt_q;
            end
            state_d = S_IDLE;
            miso_d  = MISO_IDLE;
        end else if (state_q == S_IDLE) begin
            if (cs_fall) begin
                state_d    = S_ADDR_HI;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 16'd0;
                err_d      = 1'b0;
            end
        end else if (dclk_rise) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
                S_ADDR_HI: begin
                    if (bit_cnt_q == 3'd7) begin
                        addr_d[15:8] = rx_next;
                        state_d      = S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (bit_cnt_q == 3'd7) begin
                        addr_d[7:0] = rx_next;
                        state_d     = S_CTRL;
                    end
                end
                S_CTRL: begin
                    if (bit_cnt_q == 3'd7) begin
                        bsb_d   = rx_next[7:3];
                        rwb_d   = rx_next[2];
                        om_d    = rx_next[1:0];
                        state_d = S_DATA;
                        if (!rx_next[2]) begin
                            rden_d     = 1'b1;
                            mem_addr_d = addr_q;
                            addr_d     = addr_q + 16'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (fixed_full) begin
                        err_d = 1'b1;
                    end else if (bit_cnt_q == 3'd7) begin
                        // reads prefetch the next byte so it is ready for the next fall
                        if (rwb_q) begin
                            wren_d   = 1'b1;
                            wrdata_d = rx_next;
                        end else begin
                            rden_d = 1'b1;
                        end
                        mem_addr_d = addr_q;
                        addr_d     = addr_q + 16'd1;
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end else if (dclk_fall && (state_q == S_DATA)) begin
            if (bit_cnt_q == 3'd0) begin
                miso_d  = rd_buf_q[7];
                tx_sr_d = {rd_buf_q[6:0], 1'b0};
            end else begin
                miso_d  = tx_sr_q[7];
                tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_sync_q      <= '1;
            dclk_sync_q    <= '0;
            mosi_sync_q    <= '0;
            cs_prev_q      <= 1'b1;
            dclk_prev_q    <= 1'b0;
            state_q        <= S_IDLE;
            bit_cnt_q      <= 3'd0;
            rx_sr_q        <= 8'd0;
            tx_sr_q        <= 8'd0;
            rd_buf_q       <= 8'd0;
            rd_pend_q      <= 1'b0;
            addr_q         <= 16'd0;
            bsb_q          <= 5'd0;
            rwb_q          <= 1'b0;
            om_q           <= 2'b00;
            byte_cnt_q     <= 16'd0;
            err_q          <= 1'b0;
            miso_q         <= MISO_IDLE;
            wren_q         <= 1'b0;
            rden_q         <= 1'b0;
            mem_addr_q     <= 16'd0;
            wrdata_q       <= 8'd0;
            done_q         <= 1'b0;
            ferr_q         <= 1'b0;
            byte_cnt_out_q <= 16'd0;
        end else begin
            cs_sync_q      <= cs_sync_d;
            dclk_sync_q    <= dclk_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            cs_prev_q      <= cs_s;
            dclk_prev_q    <= dclk_s;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_sr_q        <= rx_sr_d;
            tx_sr_q        <= tx_sr_d;
            rd_buf_q       <= rd_buf_d;
            rd_pend_q      <= rd_pend_d;
            addr_q         <= addr_d;
            bsb_q          <= bsb_d;
            rwb_q          <= rwb_d;
            om_q           <= om_d;
            byte_cnt_q     <= byte_cnt_d;
            err_q          <= err_d;
            miso_q         <= miso_d;
            wren_q         <= wren_d;
            rden_q         <= rden_d;
            mem_addr_q     <= mem_addr_d;
            wrdata_q       <= wrdata_d;
            done_q         <= done_d;
            ferr_q         <= ferr_d;
            byte_cnt_out_q <= byte_cnt_out_d;
        end
    end

    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = ~cs_s;
    assign o_mem_wren    = wren_q;
    assign o_mem_rden    = rden_q;
    assign o_mem_bsb     = bsb_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wrdata  = wrdata_q;
    assign o_frame_done  = done_q;
    assign o_frame_err   = ferr_q;
    assign o_byte_cnt    = byte_cnt_out_q;

endmodule

// File: tb/tb_w5500_spi_responder.sv
// Directed bench for w5500_spi_responder: an SPI master drives frames, a memory
// model answers reads, and a scoreboard checks every strobe the DUT issues.
module tb_w5500_spi_responder;

    localparam int HALF = 8;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [4:0]  bsb;
        logic [7:0]  data;
    } strobe_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_dclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic        mem_wren, mem_rden;
    logic [4:0]  mem_bsb;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wrdata;
    logic [7:0]  mem_rddata = 8'h00;
    logic        frame_done, frame_err;
    logic [15:0] byte_cnt;

    logic [7:0]  mem [0:65535];
    strobe_t     sb [$];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          d0, e0;
    logic [7:0]  rx;

    w5500_spi_responder #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
        .i_clk_50m    (clk),
        .i_rst_n      (rst_n),
        .i_spi_cs     (spi_cs),
        .i_spi_dclk   (spi_dclk),
        .i_spi_mosi   (spi_mosi),
        .o_spi_miso   (spi_miso),
        .o_spi_miso_oe(spi_miso_oe),
        .o_mem_wren   (mem_wren),
        .o_mem_rden   (mem_rden),
        .o_mem_bsb    (mem_bsb),
        .o_mem_addr   (mem_addr),
        .o_mem_wrdata (mem_wrdata),
        .i_mem_rddata (mem_rddata),
        .o_frame_done (frame_done),
        .o_frame_err  (frame_err),
        .o_byte_cnt   (byte_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mem_rden) mem_rddata <= mem[mem_addr];
        if (mem_wren) mem[mem_addr] <= mem_wrdata;
    end

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
        if (mem_wren || mem_rden) begin
            if (sb.size() == 0) begin
                chk("strobe_unexpected", {mem_wren, mem_rden, mem_addr}, 64'h0);
            end else begin
                strobe_t e;
                e = sb.pop_front();
                chk("strobe", {mem_wren, mem_rden, mem_addr, mem_bsb, mem_wren ? mem_wrdata : 8'h00},
                    {e.wr, ~e.wr, e.addr, e.bsb, e.data});
            end
        end
    end

    task automatic push(input logic wr, input logic [15:0] a, input logic [4:0] b, input logic [7:0] d);
        strobe_t s;
        s.wr = wr; s.addr = a; s.bsb = b; s.data = d;
        sb.push_back(s);
    endtask

    task automatic cs_assert();
        @(negedge clk) spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxo);
        rxo = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rxo = {rxo[6:0], spi_miso};
            spi_dclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_dclk = 1'b0;
        end
    endtask

    task automatic cs_release();
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[16'h0026] = 8'h12;
        mem[16'h0027] = 8'h34;
        mem[16'h0028] = 8'h56;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {spi_miso, spi_miso_oe, mem_wren, mem_rden, mem_bsb, mem_addr,
                              mem_wrdata, frame_done, frame_err, byte_cnt}, 64'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // VDM write
        d0 = done_cnt; e0 = err_cnt;
        push(1'b1, 16'h0010, 5'd0, 8'hAA);
        push(1'b1, 16'h0011, 5'd0, 8'h55);
        push(1'b1, 16'h0012, 5'd0, 8'hC3);
        cs_assert();
        chk("miso_oe_selected", spi_miso_oe, 1'b1);
        xfer(8'h00, 8, rx); xfer(8'h10, 8, rx); xfer(8'h04, 8, rx);
        xfer(8'hAA, 8, rx); xfer(8'h55, 8, rx); xfer(8'hC3, 8, rx);
        cs_release();
        chk("vdm_wr_sb_drained", sb.size(), 0);
        chk("vdm_wr_done", done_cnt - d0, 1);
        chk("vdm_wr_err", err_cnt - e0, 0);
        chk("vdm_wr_bytes", byte_cnt, 16'd3);
        chk("miso_oe_deselected", spi_miso_oe, 1'b0);

        // VDM read
        d0 = done_cnt; e0 = err_cnt;
        push(1'b0, 16'h0026, 5'd1, 8'h00);
        push(1'b0, 16'h0027, 5'd1, 8'h00);
        push(1'b0, 16'h0028, 5'd1, 8'h00);
        cs_assert();
        xfer(8'h00, 8, rx); xfer(8'h26, 8, rx); xfer(8'h08, 8, rx);
        xfer(8'h00, 8, rx);
        chk("vdm_rd_byte0", rx, 8'h12);
        xfer(8'h00, 8, rx);
        chk("vdm_rd_byte1", rx, 8'h34);
        chk("vdm_rd_bsb", mem_bsb, 5'd1);
        cs_release();
        chk("vdm_rd_sb_drained", sb.size(), 0);
        chk("vdm_rd_done", done_cnt - d0, 1);
        chk("vdm_rd_bytes", byte_cnt, 16'd2);

        // address wrap
        d0 = done_cnt;
        push(1'b1, 16'hFFFF, 5'd0, 8'h9A);
        push(1'b1, 16'h0000, 5'd0, 8'hBC);
        cs_assert();
        xfer(8'hFF, 8, rx); xfer(8'hFF, 8, rx); xfer(8'h04, 8, rx);
        xfer(8'h9A, 8, rx); xfer(8'hBC, 8, rx);
        cs_release();
        chk("wrap_sb_drained", sb.size(), 0);
        chk("wrap_done", done_cnt - d0, 1);
        chk("wrap_mem_ffff", mem[16'hFFFF], 8'h9A);
        chk("wrap_mem_0000", mem[16'h0000], 8'hBC);

        // fixed length 2, three bytes sent
        d0 = done_cnt; e0 = err_cnt;
        push(1'b1, 16'h0040, 5'd0, 8'h01);
        push(1'b1, 16'h0041, 5'd0, 8'h02);
        cs_assert();
        xfer(8'h00, 8, rx); xfer(8'h40, 8, rx); xfer(8'h06, 8, rx);
        xfer(8'h01, 8, rx); xfer(8'h02, 8, rx); xfer(8'h03, 8, rx);
        cs_release();
        chk("fixed_sb_drained", sb.size(), 0);
        chk("fixed_err", err_cnt - e0, 1);
        chk("fixed_done", done_cnt - d0, 0);
        chk("fixed_bytes", byte_cnt, 16'd2);

        // abort mid-byte, then clean frame
        d0 = done_cnt; e0 = err_cnt;
        push(1'b1, 16'h0200, 5'd0, 8'h11);
        cs_assert();
        xfer(8'h02, 8, rx); xfer(8'h00, 8, rx); xfer(8'h04, 8, rx);
        xfer(8'h11, 8, rx); xfer(8'h22, 5, rx);
        cs_release();
        chk("abort_sb_drained", sb.size(), 0);
        chk("abort_err", err_cnt - e0, 1);
        chk("abort_done", done_cnt - d0, 0);
        chk("abort_bytes", byte_cnt, 16'd1);

        d0 = done_cnt; e0 = err_cnt;
        push(1'b1, 16'h0300, 5'd0, 8'h77);
        push(1'b1, 16'h0301, 5'd0, 8'h88);
        cs_assert();
        xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h04, 8, rx);
        xfer(8'h77, 8, rx); xfer(8'h88, 8, rx);
        cs_release();
        chk("post_abort_done", done_cnt - d0, 1);
        chk("post_abort_err", err_cnt - e0, 0);
        chk("post_abort_bytes", byte_cnt, 16'd2);

        // reset during ADDR_LO
        d0 = done_cnt; e0 = err_cnt;
        cs_assert();
        xfer(8'h01, 8, rx); xfer(8'h23, 3, rx);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {spi_miso, spi_miso_oe, mem_wren, mem_rden, mem_bsb, mem_addr,
                                mem_wrdata, frame_done, frame_err, byte_cnt}, 64'h0);
        repeat (2) @(negedge clk);
        spi_cs = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'h0);

        d0 = done_cnt; e0 = err_cnt;
        push(1'b1, 16'h0100, 5'd0, 8'h5A);
        cs_assert();
        xfer(8'h01, 8, rx); xfer(8'h00, 8, rx); xfer(8'h04, 8, rx);
        xfer(8'h5A, 8, rx);
        cs_release();
        chk("post_rst_sb_drained", sb.size(), 0);
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_err", err_cnt - e0, 0);
        chk("post_rst_bytes", byte_cnt, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
